mem_access_unit: RTL and testbench

- Downstream of the multicycle control FSM; turns its MemRead/MemWrite/IorD/IRWrite strobes into a req/ack transaction on a variable-latency 16-bit word memory.
- Owns the instruction register (drives the controller's inst input) and the memory data register.
- Raises busy so the controller holds its current state until the access completes.

---
 rtl/mem_access_unit_pkg.sv | 18 +
 rtl/mem_access_unit_if.sv | 25 ++
 rtl/mem_access_unit_timeout.sv | 29 ++
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory access unit: state encoding, default widths
// and the timeout counter width.
package mem_access_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned TMO_CNT_W  = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  // A legal access asks for exactly one of read or write.
  function automatic logic isStart(input logic rd, input logic wr);
    return rd ^ wr;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge bus between the access unit (master) and a
// variable-latency word memory (slave).
interface mem_access_if
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_unit_timeout.sv
// Clear/enable wait-cycle counter; termCnt_c marks the TIMEOUT-th enabled
// cycle since the last clear.
module mem_timeout_ctr
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic CLK,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic termCnt_c
);
  localparam logic [TMO_CNT_W-1:0] LAST_CNT = TMO_CNT_W'(TIMEOUT - 1);

  logic [TMO_CNT_W-1:0] cntQ;

  assign termCnt_c = en && (cntQ == LAST_CNT);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cntQ <= '0;
    end else if (clr) begin
      cntQ <= '0;
    end else if (en) begin
      cntQ <= cntQ + TMO_CNT_W'(1);
    end
  end
endmodule

// File: rtl/mem_access_unit.sv
// Turns multicycle-controller memory strobes into req/ack transactions and
// owns IR/MDR. Optional access statistics under MEM_ACCESS_STATS_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IorD,
  input  logic              IRWrite,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] B,
  mem_access_if.master      mem,
  output logic [DATA_W-1:0] inst,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              err
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic [15:0]       stall_count
`endif
);

  logic [1:0]        stateQ, stateNxt;
  logic              reqQ, reqNxt;
  logic              weQ, weNxt;
  logic [ADDR_W-1:0] addrQ, addrNxt;
  logic [DATA_W-1:0] wdataQ, wdataNxt;
  logic              irLdQ, irLdNxt;
  logic [DATA_W-1:0] instQ, instNxt;
  logic [DATA_W-1:0] mdrQ, mdrNxt;
  logic              errQ, errNxt;
  logic              ctrClr, ctrEn, termCnt_c;
  logic              start;

  assign start = isStart(MemRead, MemWrite);

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .CLK       (CLK),
    .Reset     (Reset),
    .clr       (ctrClr),
    .en        (ctrEn),
    .termCnt_c (termCnt_c)
  );

  // State and registered outputs; async reset also drops an in-flight request.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      stateQ <= ST_IDLE;
      reqQ   <= 1'b0;
      weQ    <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
      irLdQ  <= 1'b0;
      instQ  <= '0;
      mdrQ   <= '0;
      errQ   <= 1'b0;
    end else begin
      stateQ <= stateNxt;
      reqQ   <= reqNxt;
      weQ    <= weNxt;
      addrQ  <= addrNxt;
      wdataQ <= wdataNxt;
      irLdQ  <= irLdNxt;
      instQ  <= instNxt;
      mdrQ   <= mdrNxt;
      errQ   <= errNxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    stateNxt = stateQ;
    reqNxt   = reqQ;
    weNxt    = weQ;
    addrNxt  = addrQ;
    wdataNxt = wdataQ;
    irLdNxt  = irLdQ;
    instNxt  = instQ;
    mdrNxt   = mdrQ;
    errNxt   = errQ;
    ctrClr   = 1'b0;
    ctrEn    = 1'b0;
    busy     = 1'b1;

    case (stateQ)
      ST_IDLE: begin
        busy   = start;
        ctrClr = 1'b1;
        if (MemRead && MemWrite) begin
          errNxt   = 1'b1;
          stateNxt = ST_ERR;
        end else if (start) begin
          reqNxt   = 1'b1;
          weNxt    = MemWrite;
          addrNxt  = IorD ? ALUOut : PC;
          wdataNxt = B;
          irLdNxt  = IRWrite & MemRead;
          stateNxt = ST_WAIT;
        end
      end

      ST_WAIT: begin
        ctrEn = 1'b1;
        // A completion in the last allowed cycle beats the timeout.
        if (mem.mem_ack) begin
          reqNxt   = 1'b0;
          ctrClr   = 1'b1;
          stateNxt = ST_IDLE;
          if (!weQ) begin
            mdrNxt = mem.mem_rdata;
            if (irLdQ) begin
              instNxt = mem.mem_rdata;
            end
          end
        end else if (termCnt_c) begin
          reqNxt   = 1'b0;
          ctrClr   = 1'b1;
          errNxt   = 1'b1;
          stateNxt = ST_ERR;
        end
      end

      ST_ERR: begin
        reqNxt = 1'b0;
      end

      default: begin
        reqNxt   = 1'b0;
        stateNxt = ST_IDLE;
      end
    endcase
  end

  assign mem.mem_req   = reqQ;
  assign mem.mem_we    = weQ;
  assign mem.mem_addr  = addrQ;
  assign mem.mem_wdata = wdataQ;
  assign inst          = instQ;
  assign mdr           = mdrQ;
  assign err           = errQ;

`ifdef MEM_ACCESS_STATS_EN
  logic rdDone, wrDone;

  assign rdDone = (stateQ == ST_WAIT) && mem.mem_ack && !weQ;
  assign wrDone = (stateQ == ST_WAIT) && mem.mem_ack && weQ;

  // Saturating activity counters.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      rd_count    <= '0;
      wr_count    <= '0;
      stall_count <= '0;
    end else begin
      if (rdDone && (rd_count != 16'hFFFF)) begin
        rd_count <= rd_count + 16'd1;
      end
      if (wrDone && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end
      if (busy && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT = 4).
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        CLK;
  logic        Reset;
  logic        MemRead, MemWrite, IorD, IRWrite;
  logic [15:0] PC, ALUOut, B;
  logic [15:0] inst, mdr;
  logic        busy, err;
  int          passCnt;
  int          totalCnt;
`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] rd_count, wr_count, stall_count;
`endif

  mem_access_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  mem_access_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IorD     (IorD),
    .IRWrite  (IRWrite),
    .PC       (PC),
    .ALUOut   (ALUOut),
    .B        (B),
    .mem      (bus.master),
    .inst     (inst),
    .mdr      (mdr),
    .busy     (busy),
    .err      (err)
`ifdef MEM_ACCESS_STATS_EN
    ,
    .rd_count    (rd_count),
    .wr_count    (wr_count),
    .stall_count (stall_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Move to 1 ns after the next rising edge; inputs are driven there and
  // outputs sampled 1 ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    MemRead = 0; MemWrite = 0; IorD = 0; IRWrite = 0;
    PC = '0; ALUOut = '0; B = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    #2;
    totalCnt++; if (bus.mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.mem_req); else passCnt++;
    totalCnt++; if (inst !== 16'h0 || mdr !== 16'h0) $display("FAIL reset_regs: got inst=%h mdr=%h want 0", inst, mdr); else passCnt++;
    totalCnt++; if (err !== 1'b0 || busy !== 1'b0) $display("FAIL reset_flags: got err=%b busy=%b want 0", err, busy); else passCnt++;
    @(negedge CLK);
    Reset = 1'b1;
  endtask

  task automatic test_fetch();
    int busyCycles;
    busyCycles = 0;
    tick();
    PC = 16'h0010; IorD = 0; MemRead = 1; IRWrite = 1;
    #1;
    if (busy === 1'b1) busyCycles++;
    totalCnt++; if (bus.mem_req !== 1'b0) $display("FAIL fetch_req_c0: got %b want 0", bus.mem_req); else passCnt++;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 3) begin bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1238; end
      if (c == 4) begin bus.mem_ack = 1'b0; MemRead = 0; IRWrite = 0; end
      #1;
      if (busy === 1'b1) busyCycles++;
      if (c == 1) begin
        totalCnt++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0010 || bus.mem_we !== 1'b0)
          $display("FAIL fetch_bus: got req=%b addr=%h we=%b want 1/0010/0", bus.mem_req, bus.mem_addr, bus.mem_we); else passCnt++;
      end
    end
    totalCnt++; if (busyCycles != 4) $display("FAIL fetch_busy_cycles: got %0d want 4", busyCycles); else passCnt++;
    totalCnt++; if (inst !== 16'h1238 || mdr !== 16'h1238) $display("FAIL fetch_data: got inst=%h mdr=%h want 1238/1238", inst, mdr); else passCnt++;
    totalCnt++; if (bus.mem_req !== 1'b0) $display("FAIL fetch_req_drop: got %b want 0", bus.mem_req); else passCnt++;
  endtask

  task automatic test_load();
    tick();
    IorD = 1; ALUOut = 16'h0042; MemRead = 1; IRWrite = 0;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hBEEF;
    #1;
    totalCnt++; if (bus.mem_addr !== 16'h0042 || bus.mem_req !== 1'b1) $display("FAIL load_bus: got addr=%h req=%b want 0042/1", bus.mem_addr, bus.mem_req); else passCnt++;
    tick();
    bus.mem_ack = 1'b0; MemRead = 0;
    #1;
    totalCnt++; if (mdr !== 16'hBEEF) $display("FAIL load_mdr: got %h want BEEF", mdr); else passCnt++;
    totalCnt++; if (inst !== 16'h1238) $display("FAIL load_inst_hold: got %h want 1238", inst); else passCnt++;
    totalCnt++; if (busy !== 1'b0) $display("FAIL load_busy: got %b want 0", busy); else passCnt++;
  endtask

  task automatic test_store();
    tick();
    MemWrite = 1; IorD = 1; ALUOut = 16'h0080; B = 16'h5A5A;
    tick();
    #1;
    totalCnt++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0080 || bus.mem_wdata !== 16'h5A5A)
      $display("FAIL store_bus: got we=%b addr=%h wdata=%h want 1/0080/5A5A", bus.mem_we, bus.mem_addr, bus.mem_wdata); else passCnt++;
    B = 16'h0000; ALUOut = 16'h0000;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hFFFF;
    #1;
    totalCnt++; if (bus.mem_wdata !== 16'h5A5A || bus.mem_addr !== 16'h0080 || bus.mem_req !== 1'b1)
      $display("FAIL store_hold: got wdata=%h addr=%h req=%b want 5A5A/0080/1", bus.mem_wdata, bus.mem_addr, bus.mem_req); else passCnt++;
    tick();
    bus.mem_ack = 1'b0; MemWrite = 0;
    #1;
    totalCnt++; if (mdr !== 16'hBEEF || inst !== 16'h1238) $display("FAIL store_regs: got mdr=%h inst=%h want BEEF/1238", mdr, inst); else passCnt++;
    totalCnt++; if (bus.mem_req !== 1'b0 || busy !== 1'b0) $display("FAIL store_done: got req=%b busy=%b want 0/0", bus.mem_req, busy); else passCnt++;
  endtask

  task automatic test_back_to_back();
    tick();
    MemRead = 1; IorD = 0; IRWrite = 0; PC = 16'h0020;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1111;
    tick();
    bus.mem_ack = 1'b0; PC = 16'h0030;
    #1;
    totalCnt++; if (busy !== 1'b1 || mdr !== 16'h1111) $display("FAIL b2b_restart: got busy=%b mdr=%h want 1/1111", busy, mdr); else passCnt++;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h2222;
    #1;
    totalCnt++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0030) $display("FAIL b2b_bus: got req=%b addr=%h want 1/0030", bus.mem_req, bus.mem_addr); else passCnt++;
    tick();
    bus.mem_ack = 1'b0; MemRead = 0;
    #1;
    totalCnt++; if (mdr !== 16'h2222 || busy !== 1'b0) $display("FAIL b2b_data: got mdr=%h busy=%b want 2222/0", mdr, busy); else passCnt++;
  endtask

  task automatic test_timeout();
    int reqCycles;
    reqCycles = 0;
    tick();
    MemRead = 1; IorD = 0; PC = 16'h0050;
    for (int c = 1; c <= 4; c++) begin
      tick();
      #1;
      if (bus.mem_req === 1'b1) reqCycles++;
    end
    totalCnt++; if (reqCycles != 4) $display("FAIL tmo_req_cycles: got %0d want 4", reqCycles); else passCnt++;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hDEAD;
    #1;
    totalCnt++; if (bus.mem_req !== 1'b0 || err !== 1'b1 || busy !== 1'b1)
      $display("FAIL tmo_err: got req=%b err=%b busy=%b want 0/1/1", bus.mem_req, err, busy); else passCnt++;
    tick();
    bus.mem_ack = 1'b0;
    #1;
    totalCnt++; if (mdr !== 16'h2222 || inst !== 16'h1238 || busy !== 1'b1 || err !== 1'b1)
      $display("FAIL tmo_late_ack: got mdr=%h inst=%h busy=%b err=%b want 2222/1238/1/1", mdr, inst, busy, err); else passCnt++;
  endtask

  task automatic test_reset_mid_wait();
    tick();
    MemRead = 0; Reset = 1'b0;
    #1;
    totalCnt++; if (err !== 1'b0 || busy !== 1'b0) $display("FAIL rst_clear_err: got err=%b busy=%b want 0/0", err, busy); else passCnt++;
    @(negedge CLK);
    Reset = 1'b1;
    tick();
    MemRead = 1; IRWrite = 1; IorD = 0; PC = 16'h0060;
    tick();
    #1;
    totalCnt++; if (bus.mem_req !== 1'b1) $display("FAIL rstw_req_up: got %b want 1", bus.mem_req); else passCnt++;
    Reset = 1'b0; MemRead = 0; IRWrite = 0;
    #1;
    totalCnt++; if (bus.mem_req !== 1'b0) $display("FAIL rstw_req_async: got %b want 0", bus.mem_req); else passCnt++;
    @(negedge CLK);
    Reset = 1'b1;
    tick();
    #1;
    totalCnt++; if (busy !== 1'b0 || bus.mem_req !== 1'b0 || inst !== 16'h0 || mdr !== 16'h0)
      $display("FAIL rstw_after: got busy=%b req=%b inst=%h mdr=%h want 0/0/0000/0000", busy, bus.mem_req, inst, mdr); else passCnt++;
  endtask

  task automatic test_conflict();
    tick();
    MemRead = 1; MemWrite = 1;
    #1;
    totalCnt++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL conf_c0: got busy=%b err=%b want 0/0", busy, err); else passCnt++;
    tick();
    #1;
    totalCnt++; if (err !== 1'b1 || bus.mem_req !== 1'b0 || busy !== 1'b1)
      $display("FAIL conf_err: got err=%b req=%b busy=%b want 1/0/1", err, bus.mem_req, busy); else passCnt++;
    tick();
    #1;
    totalCnt++; if (bus.mem_req !== 1'b0 || err !== 1'b1) $display("FAIL conf_hold: got req=%b err=%b want 0/1", bus.mem_req, err); else passCnt++;
  endtask

  initial begin
    passCnt = 0;
    totalCnt = 0;
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    test_conflict();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
